// File: rtl/ext_mem_ctrl.sv
// Round-robin arbiter in front of one external memory, with pipelined in-order read responses.
// Define EXT_MEM_BW_COUNT_EN to build the saturating bandwidth counters (otherwise tied to zero).
module ext_mem_ctrl #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int MEM_HEIGHT   = 1 << 20,
  parameter  int NUM_PORTS    = 2,
  parameter  int READ_LATENCY = 1,
  parameter  int CNT_WIDTH    = 48,
  localparam int AW           = $clog2(MEM_HEIGHT),
  localparam int PW           = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*AW-1:0]         req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic                            rsp_valid,
  output logic [PW-1:0]                   rsp_port,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [AW-1:0]                   mem_read_addr,
  output logic                            mem_read_en,
  input  logic [DATA_WIDTH-1:0]           mem_qout,
  output logic [AW-1:0]                   mem_write_addr,
  output logic [DATA_WIDTH-1:0]           mem_din,
  output logic                            mem_write_en,
  input  logic                            cnt_clear,
  output logic [CNT_WIDTH-1:0]            cnt_rd,
  output logic [CNT_WIDTH-1:0]            cnt_wr,
  output logic [CNT_WIDTH-1:0]            cnt_busy
);

  localparam logic [AW:0] ADDR_LIMIT = MEM_HEIGHT[AW:0];

  logic [PW-1:0]         rrPtr_q, rrPtr_d;
  logic                  grantFound;
  logic [PW-1:0]         grantIdx;
  logic                  selWe;
  logic [AW-1:0]         selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  selInRange;

  logic                  tagValid_q   [READ_LATENCY];
  logic [PW-1:0]         tagPort_q    [READ_LATENCY];
  logic                  tagInRange_q [READ_LATENCY];
  logic                  tagValid_d;
  logic                  tagInRange_d;
  logic [DATA_WIDTH-1:0] rdData;

  // Grants are suppressed while reset is asserted so req_ready is zero immediately.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (arst_n_in && !grantFound && req_valid[(int'(rrPtr_q) + k) % NUM_PORTS]) begin
        grantFound = 1'b1;
        grantIdx   = PW'((int'(rrPtr_q) + k) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grantFound) req_ready[grantIdx] = 1'b1;
  end

  assign selWe      = req_we[grantIdx];
  assign selAddr    = req_addr[int'(grantIdx)*AW +: AW];
  assign selWdata   = req_wdata[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
  assign selInRange = {1'b0, selAddr} < ADDR_LIMIT;

  assign mem_write_en   = grantFound & selWe & selInRange;
  assign mem_write_addr = selAddr;
  assign mem_din        = selWdata;
  assign mem_read_en    = grantFound & ~selWe & selInRange;
  assign mem_read_addr  = selAddr;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grantFound) rrPtr_d = (int'(grantIdx) == NUM_PORTS - 1) ? '0 : grantIdx + PW'(1);
  end

  assign tagValid_d   = grantFound & ~selWe;
  assign tagInRange_d = selInRange;

  // Read tags ride alongside the memory data so responses leave in grant order.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rrPtr_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        tagValid_q[s]   <= 1'b0;
        tagPort_q[s]    <= '0;
        tagInRange_q[s] <= 1'b0;
      end
    end else begin
      rrPtr_q         <= rrPtr_d;
      tagValid_q[0]   <= tagValid_d;
      tagPort_q[0]    <= grantIdx;
      tagInRange_q[0] <= tagInRange_d;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tagValid_q[s]   <= tagValid_q[s-1];
        tagPort_q[s]    <= tagPort_q[s-1];
        tagInRange_q[s] <= tagInRange_q[s-1];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : gNoDataPipe
      assign rdData = mem_qout;
    end else begin : gDataPipe
      logic [DATA_WIDTH-1:0] dataPipe_q [READ_LATENCY-1];
      always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
          for (int s = 0; s < READ_LATENCY - 1; s++) dataPipe_q[s] <= '0;
        end else begin
          dataPipe_q[0] <= mem_qout;
          for (int s = 1; s < READ_LATENCY - 1; s++) dataPipe_q[s] <= dataPipe_q[s-1];
        end
      end
      assign rdData = dataPipe_q[READ_LATENCY-2];
    end
  endgenerate

  assign rsp_valid = tagValid_q[READ_LATENCY-1];
  assign rsp_port  = tagPort_q[READ_LATENCY-1];
  assign rsp_data  = (tagValid_q[READ_LATENCY-1] && tagInRange_q[READ_LATENCY-1]) ? rdData : '0;

`ifdef EXT_MEM_BW_COUNT_EN
  logic [CNT_WIDTH-1:0] cntRd_q, cntRd_d;
  logic [CNT_WIDTH-1:0] cntWr_q, cntWr_d;
  logic [CNT_WIDTH-1:0] cntBusy_q, cntBusy_d;

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_comb begin
    cntRd_d   = cntRd_q;
    cntWr_d   = cntWr_q;
    cntBusy_d = cntBusy_q;
    if (cnt_clear) begin
      cntRd_d   = '0;
      cntWr_d   = '0;
      cntBusy_d = '0;
    end else begin
      if (mem_read_en && cntRd_q != '1) cntRd_d = cntRd_q + CNT_WIDTH'(1);
      if (mem_write_en && cntWr_q != '1) cntWr_d = cntWr_q + CNT_WIDTH'(1);
      if (|req_valid && cntBusy_q != '1) cntBusy_d = cntBusy_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      cntRd_q   <= '0;
      cntWr_q   <= '0;
      cntBusy_q <= '0;
    end else begin
      cntRd_q   <= cntRd_d;
      cntWr_q   <= cntWr_d;
      cntBusy_q <= cntBusy_d;
    end
  end

  assign cnt_rd   = cntRd_q;
  assign cnt_wr   = cntWr_q;
  assign cnt_busy = cntBusy_q;
`else
  logic unusedCntClear;
  assign unusedCntClear = cnt_clear;
  assign cnt_rd   = '0;
  assign cnt_wr   = '0;
  assign cnt_busy = '0;
`endif

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Scoreboard bench for ext_mem_ctrl: directed requests push expected read responses,
// a negedge monitor pops and compares them against rsp_valid/rsp_port/rsp_data and latency.
module tb_ext_mem_ctrl;

  localparam int DW = 32;
  localparam int MH = 100;
  localparam int NP = 2;
  localparam int RL = 3;
  localparam int CW = 4;
  localparam int AW = 7;
  localparam int PW = 1;

  logic            clk = 1'b0;
  logic            arstN;
  logic [NP-1:0]   reqValid;
  logic [NP-1:0]   reqReady;
  logic [NP-1:0]   reqWe;
  logic [NP*AW-1:0] reqAddr;
  logic [NP*DW-1:0] reqWdata;
  logic            rspValid;
  logic [PW-1:0]   rspPort;
  logic [DW-1:0]   rspData;
  logic [AW-1:0]   memReadAddr;
  logic            memReadEn;
  logic [DW-1:0]   memQout;
  logic [AW-1:0]   memWriteAddr;
  logic [DW-1:0]   memDin;
  logic            memWriteEn;
  logic            cntClear;
  logic [CW-1:0]   cntRd;
  logic [CW-1:0]   cntWr;
  logic [CW-1:0]   cntBusy;

  typedef struct {
    logic [PW-1:0] port;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t       expQ[$];
  rsp_t       expHead;
  int         cyc;
  int         checks;
  int         fails;
  logic [DW-1:0] extMem [1 << AW];
  bit            memWritten [1 << AW];
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;
  int            n0;
  int            n1;

  ext_mem_ctrl #(
    .DATA_WIDTH(DW), .MEM_HEIGHT(MH), .NUM_PORTS(NP), .READ_LATENCY(RL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .arst_n_in(arstN),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_port(rspPort), .rsp_data(rspData),
    .mem_read_addr(memReadAddr), .mem_read_en(memReadEn), .mem_qout(memQout),
    .mem_write_addr(memWriteAddr), .mem_din(memDin), .mem_write_en(memWriteEn),
    .cnt_clear(cntClear), .cnt_rd(cntRd), .cnt_wr(cntWr), .cnt_busy(cntBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations hold a fixed address-derived pattern.
  function automatic logic [DW-1:0] patternOf(input logic [AW-1:0] a);
    return {4{1'b0, a}};
  endfunction

  // Synchronous external memory: one cycle read latency, read-before-write on the same edge.
  always @(posedge clk) begin
    if (memWriteEn) begin
      extMem[memWriteAddr]     <= memDin;
      memWritten[memWriteAddr] <= 1'b1;
    end
    if (memReadEn) memQout <= memWritten[memReadAddr] ? extMem[memReadAddr] : patternOf(memReadAddr);
  end

  function automatic logic [63:0] cntExp(input int v);
`ifdef EXT_MEM_BW_COUNT_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                               input logic [AW-1:0] addr0, input logic [AW-1:0] addr1,
                               input logic [DW-1:0] data0, input logic [DW-1:0] data1,
                               input logic clr);
    @(posedge clk);
    #1;
    reqValid = valid;
    reqWe    = we;
    reqAddr  = {addr1, addr0};
    reqWdata = {data1, data0};
    cntClear = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic expectRead(input logic [PW-1:0] port, input logic [DW-1:0] data);
    rsp_t e;
    e.port = port;
    e.data = data;
    e.cyc  = cyc + RL;
    expQ.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(reqReady), 0);
    checkOutput({tag, "_rsp_valid"}, 64'(rspValid), 0);
    checkOutput({tag, "_rsp_port"}, 64'(rspPort), 0);
    checkOutput({tag, "_rsp_data"}, 64'(rspData), 0);
    checkOutput({tag, "_mem_read_en"}, 64'(memReadEn), 0);
    checkOutput({tag, "_mem_write_en"}, 64'(memWriteEn), 0);
    checkOutput({tag, "_mem_read_addr"}, 64'(memReadAddr), 0);
    checkOutput({tag, "_mem_write_addr"}, 64'(memWriteAddr), 0);
    checkOutput({tag, "_mem_din"}, 64'(memDin), 0);
    checkOutput({tag, "_cnt_rd"}, 64'(cntRd), 0);
    checkOutput({tag, "_cnt_wr"}, 64'(cntWr), 0);
    checkOutput({tag, "_cnt_busy"}, 64'(cntBusy), 0);
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rspValid) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_rsp: got port %0d data 0x%0h, expected no response (cycle %0d)",
                 rspPort, rspData, cyc);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("rsp_port", 64'(rspPort), 64'(expHead.port));
        checkOutput("rsp_data", 64'(rspData), 64'(expHead.data));
        checkOutput("rsp_cycle", 64'(cyc), 64'(expHead.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arstN    = 1'b0;
    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    cntClear = 1'b0;

    // Reset with all inputs low, then release.
    repeat (3) @(negedge clk);
    checkAllZero("rst");
    @(posedge clk);
    #1 arstN = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("post_rst");

    // Write then read-after-write from the other port.
    applyStimulus(2'b01, 2'b01, 7'h10, 7'h00, 32'hDEADBEEF, 32'h0, 1'b0);
    checkOutput("wr_ready", 64'(reqReady), 64'h1);
    checkOutput("wr_en", 64'(memWriteEn), 64'h1);
    checkOutput("wr_addr", 64'(memWriteAddr), 64'h10);
    checkOutput("wr_din", 64'(memDin), 64'hDEADBEEF);
    checkOutput("wr_no_rd_en", 64'(memReadEn), 64'h0);
    applyStimulus(2'b10, 2'b00, 7'h00, 7'h10, 32'h0, 32'h0, 1'b0);
    checkOutput("rd_ready", 64'(reqReady), 64'h2);
    checkOutput("rd_en", 64'(memReadEn), 64'h1);
    checkOutput("rd_addr", 64'(memReadAddr), 64'h10);
    expectRead(1'b1, 32'hDEADBEEF);
    idle(4);
    checkOutput("cnt_rd_raw", 64'(cntRd), cntExp(1));
    checkOutput("cnt_wr_raw", 64'(cntWr), cntExp(1));
    checkOutput("cnt_busy_raw", 64'(cntBusy), cntExp(2));

    // Both ports streaming reads: strict alternation starting at port 0.
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      a0 = AW'(32'h20 + n0);
      a1 = AW'(32'h40 + n1);
      applyStimulus(2'b11, 2'b00, a0, a1, '0, '0, 1'b0);
      if (k % 2 == 0) begin
        checkOutput("rr_grant_p0", 64'(reqReady), 64'h1);
        expectRead(1'b0, patternOf(a0));
        n0++;
      end else begin
        checkOutput("rr_grant_p1", 64'(reqReady), 64'h2);
        expectRead(1'b1, patternOf(a1));
        n1++;
      end
    end
    idle(4);
    checkOutput("cnt_rd_stream", 64'(cntRd), cntExp(8));
    checkOutput("cnt_busy_stream", 64'(cntBusy), cntExp(8));
    checkOutput("cnt_wr_stream", 64'(cntWr), cntExp(0));

    // Out-of-range read and write: granted but never reach memory.
    applyStimulus(2'b01, 2'b00, 7'd100, 7'd0, '0, '0, 1'b0);
    checkOutput("oor_rd_ready", 64'(reqReady), 64'h1);
    checkOutput("oor_rd_en", 64'(memReadEn), 64'h0);
    expectRead(1'b0, 32'h0);
    applyStimulus(2'b01, 2'b01, 7'd100, 7'd0, 32'h12345678, '0, 1'b0);
    checkOutput("oor_wr_ready", 64'(reqReady), 64'h1);
    checkOutput("oor_wr_en", 64'(memWriteEn), 64'h0);
    idle(4);
    checkOutput("oor_cnt_wr", 64'(cntWr), cntExp(0));
    checkOutput("oor_cnt_rd", 64'(cntRd), cntExp(8));

    // Two reads in flight, then an asynchronous reset mid-cycle.
    applyStimulus(2'b11, 2'b00, 7'h21, 7'h41, '0, '0, 1'b0);
    checkOutput("pre_rst_grant_p1", 64'(reqReady), 64'h2);
    applyStimulus(2'b01, 2'b00, 7'h21, 7'h41, '0, '0, 1'b0);
    checkOutput("pre_rst_grant_p0", 64'(reqReady), 64'h1);
    @(posedge clk);
    #1;
    arstN    = 1'b0;
    reqValid = 2'b11;
    reqWe    = 2'b00;
    #1;
    checkOutput("async_rst_ready", 64'(reqReady), 64'h0);
    checkOutput("async_rst_rd_en", 64'(memReadEn), 64'h0);
    checkOutput("async_rst_cnt_rd", 64'(cntRd), 64'h0);
    checkOutput("async_rst_cnt_busy", 64'(cntBusy), 64'h0);
    repeat (2) @(negedge clk);
    checkOutput("in_rst_rsp_valid", 64'(rspValid), 64'h0);
    @(posedge clk);
    #1 arstN = 1'b1;
    @(negedge clk);
    checkOutput("rr_after_rst", 64'(reqReady), 64'h1);
    expectRead(1'b0, patternOf(7'h21));
    idle(5);

    // Saturation at 4 bits, then clear coincident with a write.
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(2'b01, 2'b01, AW'(i), '0, 32'hA000_0000 + DW'(i), '0, 1'b0);
    idle(1);
    checkOutput("cnt_wr_sat", 64'(cntWr), cntExp(15));
    applyStimulus(2'b01, 2'b01, 7'd20, '0, 32'hA000_0014, '0, 1'b1);
    checkOutput("clr_wr_en", 64'(memWriteEn), 64'h1);
    idle(1);
    checkOutput("cnt_wr_cleared", 64'(cntWr), cntExp(0));
    applyStimulus(2'b01, 2'b01, 7'd21, '0, 32'hA000_0015, '0, 1'b0);
    idle(1);
    checkOutput("cnt_wr_after_clr", 64'(cntWr), cntExp(1));
    applyStimulus(2'b01, 2'b00, 7'd5, '0, '0, '0, 1'b0);
    checkOutput("readback_ready", 64'(reqReady), 64'h1);
    expectRead(1'b0, 32'hA000_0005);
    idle(6);

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
